prefix_subtractor_pipe: RTL and testbench

Pipelined parallel-prefix subtractor computing diff = a − b − bin with a borrow-out and a signed-overflow flag. It is the subtraction counterpart of the team's combinational prefix adder. Internally it uses the same Kogge-Stone carry network on {a, ~b, ~bin}, split across two register stages. Valid/ready handshakes on both sides let it sit between streaming producers and consumers in the datapath.

---
 rtl/prefix_subtractor_pipe.sv | 76 +++++++
 tb/tb_prefix_subtractor_pipe.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/prefix_subtractor_pipe.sv
// prefix_subtractor_pipe: two-stage Kogge-Stone subtractor (a - b - bin) with valid/ready flow control
module prefix_subtractor_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);
  localparam int L  = $clog2(WIDTH);
  localparam int L1 = (L + 1) / 2;
  logic s1_valid, s2_valid, s1_adv, s2_adv;
  logic [WIDTH-1:0] g_r, p_r, x_r;
  logic c0_r, am_r, nbm_r;
  logic [WIDTH-1:0] gt [0:L];
  logic [WIDTH-1:0] pt [0:L];
  logic [WIDTH-1:0] gq [0:L-1];
  logic [WIDTH-1:0] pq [0:L-1];
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] diff_n;
  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;
  assign gt[0] = a & ~b;
  assign pt[0] = a ^ ~b;
  // levels below L1 see the live operands, the rest see the stage-1 registers
  for (genvar k = 0; k < L; k++) begin : g_lvl
    localparam int S = 1 << k;
    assign gq[k] = (k == L1) ? g_r : gt[k];
    assign pq[k] = (k == L1) ? p_r : pt[k];
    assign gt[k+1] = gq[k] | (pq[k] & (gq[k] << S));
    assign pt[k+1] = pq[k] & ((pq[k] << S) | ~({WIDTH{1'b1}} << S));
  end
  assign c      = {gt[L] | (pt[L] & {WIDTH{c0_r}}), c0_r};
  assign diff_n = x_r ^ c[WIDTH-1:0];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      g_r      <= '0;
      p_r      <= '0;
      x_r      <= '0;
      c0_r     <= 1'b0;
      am_r     <= 1'b0;
      nbm_r    <= 1'b0;
      diff     <= '0;
      bout     <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      if (s1_adv) s1_valid <= in_valid;
      if (s2_adv) s2_valid <= s1_valid;
      if (s1_adv && in_valid) begin
        g_r   <= gt[L1];
        p_r   <= pt[L1];
        x_r   <= pt[0];
        c0_r  <= ~bin;
        am_r  <= a[WIDTH-1];
        nbm_r <= ~b[WIDTH-1];
      end
      if (s2_adv && s1_valid) begin
        diff <= diff_n;
        bout <= ~c[WIDTH];
        ovf  <= (am_r == nbm_r) && (diff_n[WIDTH-1] != am_r);
      end
    end
  end
endmodule

// File: tb/tb_prefix_subtractor_pipe.sv
// tb_prefix_subtractor_pipe: directed and scoreboarded random checks at WIDTH 8 and 16
module tb_prefix_subtractor_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic iv8, ir8, bi8, ov8, or8, bo8, of8;
  logic [7:0] a8, b8, d8;
  logic iv16, ir16, bi16, ov16, or16, bo16, of16;
  logic [15:0] a16, b16, d16;
  int total = 0;
  int bad = 0;
  prefix_subtractor_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .bin(bi8),
    .out_valid(ov8), .out_ready(or8), .diff(d8), .bout(bo8), .ovf(of8)
  );
  prefix_subtractor_pipe #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16), .bin(bi16),
    .out_valid(ov16), .out_ready(or16), .diff(d16), .bout(bo16), .ovf(of16)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] mdl(input int w, input logic [63:0] a, input logic [63:0] b, input logic bi);
    logic [64:0] s;
    logic [63:0] m, d;
    logic bo, ov;
    m  = (64'd1 << w) - 64'd1;
    s  = {1'b0, a & m} + {1'b0, ~b & m} + 65'(!bi);
    d  = s[63:0] & m;
    bo = !s[w];
    ov = (a[w-1] != b[w-1]) && (d[w-1] != a[w-1]);
    return d | (64'(bo) << w) | (64'(ov) << (w + 1));
  endfunction
  task automatic dir8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic bi,
                      input logic [7:0] ed, input logic ebo, input logic eof);
    a8 = a; b8 = b; bi8 = bi; iv8 = 1'b1; or8 = 1'b1;
    #1 chk({tag, "_rdy"}, 64'(ir8), 64'd1);
    @(posedge clk); #1;
    iv8 = 1'b0;
    chk({tag, "_v1"}, 64'(ov8), 64'd0);
    @(posedge clk); #1;
    chk({tag, "_v2"}, 64'(ov8), 64'd1);
    chk({tag, "_res"}, {61'd0, of8, bo8, d8} & 64'h3ff, {54'd0, eof, ebo, ed});
    @(posedge clk); #1;
    chk({tag, "_v3"}, 64'(ov8), 64'd0);
  endtask
  task automatic rnd8();
    logic [63:0] q[$];
    logic [63:0] e;
    int sent = 0, rcvd = 0, cyc = 0;
    logic fin;
    iv8 = 1'b0;
    while (rcvd < 1000 && cyc < 20000) begin
      if (!iv8 && sent < 1000) begin
        a8 = 8'($urandom); b8 = 8'($urandom); bi8 = 1'($urandom); iv8 = 1'b1;
      end
      or8 = 1'($urandom_range(0, 1));
      #1;
      fin = iv8 && ir8;
      if (fin) begin q.push_back(mdl(8, 64'(a8), 64'(b8), bi8)); sent++; end
      if (ov8 && or8) begin
        if (q.size() == 0) chk("r8_extra", 64'd1, 64'd0);
        else begin e = q.pop_front(); chk("r8", {54'd0, of8, bo8, d8}, e); end
        rcvd++;
      end
      @(posedge clk); #1;
      if (fin) iv8 = 1'b0;
      cyc++;
    end
    chk("r8_cnt", 64'(rcvd), 64'd1000);
  endtask
  task automatic rnd16();
    logic [63:0] q[$];
    logic [63:0] e;
    int sent = 0, rcvd = 0, cyc = 0;
    logic fin;
    iv16 = 1'b0;
    while (rcvd < 1000 && cyc < 20000) begin
      if (!iv16 && sent < 1000) begin
        a16 = 16'($urandom); b16 = 16'($urandom); bi16 = 1'($urandom); iv16 = 1'b1;
      end
      or16 = 1'($urandom_range(0, 1));
      #1;
      fin = iv16 && ir16;
      if (fin) begin q.push_back(mdl(16, 64'(a16), 64'(b16), bi16)); sent++; end
      if (ov16 && or16) begin
        if (q.size() == 0) chk("r16_extra", 64'd1, 64'd0);
        else begin e = q.pop_front(); chk("r16", {46'd0, of16, bo16, d16}, e); end
        rcvd++;
      end
      @(posedge clk); #1;
      if (fin) iv16 = 1'b0;
      cyc++;
    end
    chk("r16_cnt", 64'(rcvd), 64'd1000);
  endtask
  initial begin
    logic [7:0] bpa [4];
    logic [7:0] bpd [4];
    int acc, got;
    logic fin;
    bpa = '{8'h10, 8'h20, 8'h30, 8'h40};
    bpd = '{8'h0f, 8'h1e, 8'h2d, 8'h3c};
    iv8 = 1'b0; or8 = 1'b1; a8 = '0; b8 = '0; bi8 = 1'b0;
    iv16 = 1'b0; or16 = 1'b1; a16 = '0; b16 = '0; bi16 = 1'b0;
    #1;
    chk("rst_ov8", 64'(ov8), 64'd0);
    chk("rst_d8", 64'({bo8, of8, d8}), 64'd0);
    chk("rst_ir8", 64'(ir8), 64'd1);
    chk("rst_ov16", 64'(ov16), 64'd0);
    chk("rst_d16", 64'({bo16, of16, d16}), 64'd0);
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    dir8("basic", 8'h5a, 8'h3c, 1'b0, 8'h1e, 1'b0, 1'b0);
    dir8("wrap1", 8'h00, 8'h01, 1'b0, 8'hff, 1'b1, 1'b0);
    dir8("wrap2", 8'h00, 8'h00, 1'b1, 8'hff, 1'b1, 1'b0);
    dir8("ovfn", 8'h80, 8'h01, 1'b0, 8'h7f, 1'b0, 1'b1);
    dir8("ovfp", 8'h7f, 8'hff, 1'b0, 8'h80, 1'b1, 1'b1);
    dir8("zero", 8'h10, 8'h0f, 1'b1, 8'h00, 1'b0, 1'b0);
    acc = 0;
    or8 = 1'b0;
    for (int c = 0; c < 4; c++) begin
      a8 = bpa[acc]; b8 = 8'(acc + 1); bi8 = 1'b0; iv8 = 1'b1;
      #1 fin = ir8;
      @(posedge clk); #1;
      if (fin) acc++;
    end
    chk("bp_acc", 64'(acc), 64'd2);
    chk("bp_ir", 64'(ir8), 64'd0);
    chk("bp_hold", 64'({ov8, d8}), 64'h10f);
    got = 0;
    or8 = 1'b1;
    for (int c = 0; c < 4; c++) begin
      iv8 = (acc < 4);
      if (acc < 4) begin a8 = bpa[acc]; b8 = 8'(acc + 1); end
      #1 fin = iv8 && ir8;
      if (ov8) begin
        chk("bp_out", 64'(d8), 64'(bpd[got < 4 ? got : 3]));
        got++;
      end
      @(posedge clk); #1;
      if (fin) acc++;
    end
    iv8 = 1'b0;
    chk("bp_cnt", 64'(got), 64'd4);
    chk("bp_empty", 64'(ov8), 64'd0);
    or8 = 1'b0;
    a8 = 8'h55; b8 = 8'h11; iv8 = 1'b1;
    @(posedge clk); #1;
    a8 = 8'h66; b8 = 8'h22;
    @(posedge clk); #1;
    iv8 = 1'b0;
    chk("mid_pre", 64'(ov8), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_ov", 64'(ov8), 64'd0);
    chk("mid_d", 64'(d8), 64'd0);
    chk("mid_ir", 64'(ir8), 64'd1);
    #3 rst_n = 1'b1;
    or8 = 1'b1;
    got = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (ov8) got++;
    end
    chk("mid_stale", 64'(got), 64'd0);
    fork
      rnd8();
      rnd16();
    join
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
